// File: rtl/umi_printer_if.sv
// UMI request-port bundle for umi_printer.
// The printer drives the host request channel and receives the unused device request channel.
interface umi_printer_if #(
   parameter int CMD_WIDTH  = 32,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 128
);
   logic                  uhost_req_valid;
   logic [CMD_WIDTH-1:0]  uhost_req_cmd;
   logic [ADDR_WIDTH-1:0] uhost_req_dstaddr;
   logic [ADDR_WIDTH-1:0] uhost_req_srcaddr;
   logic [DATA_WIDTH-1:0] uhost_req_data;
   logic                  uhost_req_ready;

   logic                  udev_req_valid;
   logic [CMD_WIDTH-1:0]  udev_req_cmd;
   logic [ADDR_WIDTH-1:0] udev_req_dstaddr;
   logic [ADDR_WIDTH-1:0] udev_req_srcaddr;
   logic [DATA_WIDTH-1:0] udev_req_data;
   logic                  udev_req_ready;

   modport master (
      output uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data,
      input  uhost_req_ready,
      input  udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data,
      output udev_req_ready
   );

   modport slave (
      input  uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data,
      output uhost_req_ready,
      output udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data,
      input  udev_req_ready
   );
endinterface

// File: rtl/umi_printer.sv
// UMI host-side message source: streams a constant ASCII message to PUTC_ADDR as posted
// writes, packing several characters per request, with repeat, inter-pass gap and start/busy/done.
module umi_printer #(
   parameter int                     CMD_WIDTH     = 32,
   parameter int                     ADDR_WIDTH    = 64,
   parameter int                     DATA_WIDTH    = 128,
   parameter int                     MSG_LEN       = 13,
   parameter logic [8*MSG_LEN-1:0]   MESSAGE       = "Hello World!\n",
   parameter int                     BYTES_PER_REQ = 1,
   parameter logic [ADDR_WIDTH-1:0]  PUTC_ADDR     = 'h1000000,
   parameter int                     REPEAT        = 1,
   parameter int                     GAP_CYCLES    = 0,
   parameter bit                     AUTOSTART     = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   umi_printer_if.master umi
);
   localparam int NCHUNK = (MSG_LEN + BYTES_PER_REQ - 1) / BYTES_PER_REQ;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int NSLOT  = 1 << IDX_W;
   localparam logic [IDX_W-1:0] LAST_CHUNK = IDX_W'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   // Chunk k payload: character k*B+b lands in byte b; slots past the message stay zero.
   function automatic logic [DATA_WIDTH-1:0] pack_chunk(input int k);
      logic [DATA_WIDTH-1:0] d;
      int                    i;
      d = '0;
      for (int b = 0; b < BYTES_PER_REQ; b++) begin
         i = k * BYTES_PER_REQ + b;
         if (i < MSG_LEN) d[8*b +: 8] = MESSAGE[8*(MSG_LEN-1-i) +: 8];
      end
      return d;
   endfunction

   function automatic logic [CMD_WIDTH-1:0] pack_cmd(input int k);
      logic [CMD_WIDTH-1:0] c;
      int                   nb;
      c  = '0;
      nb = MSG_LEN - k * BYTES_PER_REQ;
      if (nb > BYTES_PER_REQ) nb = BYTES_PER_REQ;
      if (nb > 0) begin
         c[7:0]  = 8'h05;
         c[15:8] = 8'(nb - 1);
      end
      return c;
   endfunction

   logic [DATA_WIDTH-1:0] chunk_data [NSLOT];
   logic [CMD_WIDTH-1:0]  chunk_cmd  [NSLOT];

   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_rom
         assign chunk_data[gi] = pack_chunk(gi);
         assign chunk_cmd[gi]  = pack_cmd(gi);
      end
   endgenerate

   state_t                state_reg;
   logic [IDX_W-1:0]      chunk_reg;
   logic [31:0]           pass_reg;
   logic [15:0]           gap_reg;
   logic                  valid_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  auto_reg;
   logic [CMD_WIDTH-1:0]  cmd_reg;
   logic [DATA_WIDTH-1:0] data_reg;
   logic [ADDR_WIDTH-1:0] dst_reg;

   logic [IDX_W-1:0] chunk_next;
   logic [31:0]      pass_next;
   logic             last_pass;

   assign chunk_next = chunk_reg + 1'b1;
   assign pass_next  = pass_reg + 32'd1;
   assign last_pass  = (REPEAT != 0) && (pass_next == 32'(REPEAT));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         chunk_reg <= '0;
         pass_reg  <= '0;
         gap_reg   <= '0;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         auto_reg  <= AUTOSTART;
         cmd_reg   <= '0;
         data_reg  <= '0;
         dst_reg   <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // The done cycle is still spent in IDLE, so a start landing on it is dropped.
               if ((auto_reg || start) && !done_reg) begin
                  auto_reg  <= 1'b0;
                  state_reg <= SEND;
                  valid_reg <= 1'b1;
                  busy_reg  <= 1'b1;
                  chunk_reg <= '0;
                  pass_reg  <= '0;
                  cmd_reg   <= chunk_cmd[0];
                  data_reg  <= chunk_data[0];
                  dst_reg   <= PUTC_ADDR;
               end
            end
            SEND: begin
               if (umi.uhost_req_ready) begin
                  if (chunk_reg != LAST_CHUNK) begin
                     chunk_reg <= chunk_next;
                     cmd_reg   <= chunk_cmd[chunk_next];
                     data_reg  <= chunk_data[chunk_next];
                  end else begin
                     chunk_reg <= '0;
                     if (REPEAT != 0 && pass_reg != '1) pass_reg <= pass_next;
                     if (last_pass) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                     end else if (GAP_CYCLES == 0) begin
                        cmd_reg  <= chunk_cmd[0];
                        data_reg <= chunk_data[0];
                     end else begin
                        state_reg <= GAP;
                        valid_reg <= 1'b0;
                        gap_reg   <= 16'(GAP_CYCLES - 1);
                     end
                  end
               end
            end
            GAP: begin
               if (gap_reg == '0) begin
                  state_reg <= SEND;
                  valid_reg <= 1'b1;
                  cmd_reg   <= chunk_cmd[0];
                  data_reg  <= chunk_data[0];
               end else begin
                  gap_reg <= gap_reg - 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Device port is a stub: its inputs are folded into a term that is masked to zero.
   logic udev_sink;
   assign udev_sink = umi.udev_req_valid ^ (^umi.udev_req_cmd) ^ (^umi.udev_req_dstaddr)
                    ^ (^umi.udev_req_srcaddr) ^ (^umi.udev_req_data);
   assign umi.udev_req_ready = udev_sink & 1'b0;

   assign umi.uhost_req_valid   = valid_reg;
   assign umi.uhost_req_cmd     = cmd_reg;
   assign umi.uhost_req_dstaddr = dst_reg;
   assign umi.uhost_req_srcaddr = '0;
   assign umi.uhost_req_data    = data_reg;
   assign busy                  = busy_reg;
   assign done                  = done_reg;
endmodule

// File: tb/tb_umi_printer.sv
// Self-checking bench for umi_printer: four instances cover default streaming with back-pressure
// and mid-run reset, 4-byte packing, repeat with gap, and start-controlled runs.
module tb_umi_printer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   logic start0, start1, start2, start3;
   logic busy0, busy1, busy2, busy3;
   logic done0, done1, done2, done3;

   umi_printer_if if0 ();
   umi_printer_if if1 ();
   umi_printer_if if2 ();
   umi_printer_if if3 ();

   umi_printer u0 (.clk(clk), .reset(rst_a), .start(start0), .busy(busy0), .done(done0), .umi(if0));
   umi_printer #(.BYTES_PER_REQ(4)) u1 (
      .clk(clk), .reset(rst_b), .start(start1), .busy(busy1), .done(done1), .umi(if1));
   umi_printer #(.REPEAT(3), .GAP_CYCLES(4)) u2 (
      .clk(clk), .reset(rst_b), .start(start2), .busy(busy2), .done(done2), .umi(if2));
   umi_printer #(.AUTOSTART(0)) u3 (
      .clk(clk), .reset(rst_b), .start(start3), .busy(busy3), .done(done3), .umi(if3));

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   logic [7:0] msg [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                            8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

   typedef struct {
      logic       ready;
      logic       valid;
      logic       busy;
      logic       done;
      logic [7:0] chr;
   } row_t;
   row_t tbl [21];

   typedef struct {
      logic [31:0]  cmd;
      logic [127:0] data;
   } pkt_t;
   pkt_t exp1 [4];

   // Transfer monitors, sampled on the falling edge.
   pkt_t q1 [$];
   int   done1_cnt = 0;
   always @(negedge clk) begin
      if (if1.uhost_req_valid && if1.uhost_req_ready)
         q1.push_back('{if1.uhost_req_cmd, if1.uhost_req_data});
      if (done1) done1_cnt++;
   end

   logic [7:0] q2 [$];
   int gap_runs [$];
   int gap_run = 0, done2_cnt = 0, busy_drop = 0, n2_at_done = -1;
   always @(negedge clk) begin
      if (done2) begin
         done2_cnt++;
         if (n2_at_done < 0) n2_at_done = q2.size();
      end
      if (!busy2 && q2.size() > 0 && done2_cnt == 0) busy_drop++;
      if (busy2 && !if2.uhost_req_valid) gap_run++;
      else if (gap_run != 0) begin
         gap_runs.push_back(gap_run);
         gap_run = 0;
      end
      if (if2.uhost_req_valid && if2.uhost_req_ready) q2.push_back(if2.uhost_req_data[7:0]);
   end

   int n3 = 0;
   always @(negedge clk) if (if3.uhost_req_valid && if3.uhost_req_ready) n3++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int n, guard, extra, bad;
      rst_a = 1'b1;
      rst_b = 1'b1;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
      if0.uhost_req_ready = 1'b0;
      if1.uhost_req_ready = 1'b1;
      if2.uhost_req_ready = 1'b1;
      if3.uhost_req_ready = 1'b1;
      if0.udev_req_valid = 1'b1; if0.udev_req_cmd = 32'h1234_0005;
      if0.udev_req_dstaddr = 64'hDEAD; if0.udev_req_srcaddr = 64'hBEEF; if0.udev_req_data = 128'hA5;
      if1.udev_req_valid = 1'b0; if1.udev_req_cmd = '0;
      if1.udev_req_dstaddr = '0; if1.udev_req_srcaddr = '0; if1.udev_req_data = '0;
      if2.udev_req_valid = 1'b1; if2.udev_req_cmd = 32'h5;
      if2.udev_req_dstaddr = 64'h1; if2.udev_req_srcaddr = 64'h2; if2.udev_req_data = 128'h3;
      if3.udev_req_valid = 1'b0; if3.udev_req_cmd = '0;
      if3.udev_req_dstaddr = '0; if3.udev_req_srcaddr = '0; if3.udev_req_data = '0;

      // Default instance, one row per cycle: ready applied, outputs expected after that edge.
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h48};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h65};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h6C};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h6C};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h6F};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h20};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h57};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h57};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h57};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h57};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h57};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h57};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h6F};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h72};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h6C};
      tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h64};
      tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h21};
      tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h0A};
      tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

      exp1[0] = '{32'h305, 128'h6C6C6548};
      exp1[1] = '{32'h305, 128'h6F57206F};
      exp1[2] = '{32'h305, 128'h21646C72};
      exp1[3] = '{32'h005, 128'h0A};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 128'(if0.uhost_req_valid), 128'd0);
      check("rst_busy", 128'(busy0), 128'd0);
      check("rst_done", 128'(done0), 128'd0);
      check("rst_cmd", 128'(if0.uhost_req_cmd), 128'd0);
      check("rst_dst", 128'(if0.uhost_req_dstaddr), 128'd0);
      check("rst_data", if0.uhost_req_data, 128'd0);
      check("udev_ready", 128'(if0.udev_req_ready), 128'd0);
      @(posedge clk); #1;
      rst_a = 1'b0;
      rst_b = 1'b0;

      for (int r = 0; r < 21; r++) begin
         @(posedge clk); #1;
         if0.uhost_req_ready = tbl[r].ready;
         @(negedge clk);
         $display("row %0d: ready=%0b valid=%0b busy=%0b done=%0b data=%0h", r, tbl[r].ready,
                  if0.uhost_req_valid, busy0, done0, if0.uhost_req_data);
         check($sformatf("row%0d_valid", r), 128'(if0.uhost_req_valid), 128'(tbl[r].valid));
         check($sformatf("row%0d_busy", r), 128'(busy0), 128'(tbl[r].busy));
         check($sformatf("row%0d_done", r), 128'(done0), 128'(tbl[r].done));
         if (tbl[r].valid) begin
            check($sformatf("row%0d_data", r), if0.uhost_req_data, 128'(tbl[r].chr));
            check($sformatf("row%0d_cmd", r), 128'(if0.uhost_req_cmd), 128'h05);
            check($sformatf("row%0d_dst", r), 128'(if0.uhost_req_dstaddr), 128'h1000000);
            check($sformatf("row%0d_src", r), 128'(if0.uhost_req_srcaddr), 128'd0);
         end
      end

      // Mid-run reset after the sixth transfer, then a full restart.
      @(posedge clk); #1 rst_a = 1'b1;
      @(posedge clk); #1 rst_a = 1'b0;
      n = 0; guard = 0;
      while (n < 6 && guard < 50) begin
         @(negedge clk);
         if (if0.uhost_req_valid && if0.uhost_req_ready) n++;
         guard++;
      end
      check("mid_pre_count", 128'(n), 128'd6);
      @(posedge clk); #1 rst_a = 1'b1;
      @(negedge clk);
      check("mid_pre_byte", if0.uhost_req_data, 128'h57);
      @(posedge clk); #1;
      @(negedge clk);
      $display("mid reset edge: valid=%0b busy=%0b data=%0h", if0.uhost_req_valid, busy0,
               if0.uhost_req_data);
      check("mid_rst_valid", 128'(if0.uhost_req_valid), 128'd0);
      check("mid_rst_busy", 128'(busy0), 128'd0);
      check("mid_rst_data", if0.uhost_req_data, 128'd0);
      @(posedge clk); #1 rst_a = 1'b0;
      n = 0; guard = 0;
      while (n < 13 && guard < 100) begin
         @(negedge clk);
         if (if0.uhost_req_valid && if0.uhost_req_ready) begin
            $display("mid xfer %0d: data=%0h", n, if0.uhost_req_data[7:0]);
            check($sformatf("mid_byte%0d", n), 128'(if0.uhost_req_data[7:0]), 128'(msg[n]));
            n++;
         end
         guard++;
      end
      check("mid_count", 128'(n), 128'd13);
      guard = 0;
      while (!done0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      check("mid_done", 128'(done0), 128'd1);
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         if (if0.uhost_req_valid) extra++;
      end
      check("mid_no_extra", 128'(extra), 128'd0);

      // Four-byte packing.
      @(posedge clk); #1;
      $display("u1: %0d transfers, %0d done pulses", q1.size(), done1_cnt);
      check("u1_count", 128'(q1.size()), 128'd4);
      check("u1_done_cnt", 128'(done1_cnt), 128'd1);
      for (int k = 0; k < 4 && k < q1.size(); k++) begin
         check($sformatf("u1_cmd%0d", k), 128'(q1[k].cmd), 128'(exp1[k].cmd));
         check($sformatf("u1_data%0d", k), q1[k].data, exp1[k].data);
      end

      // Repeat with gap.
      guard = 0;
      while (done2_cnt == 0 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      repeat (5) @(posedge clk);
      #1;
      $display("u2: %0d transfers, %0d gap runs, done after %0d", q2.size(), gap_runs.size(),
               n2_at_done);
      check("u2_done_cnt", 128'(done2_cnt), 128'd1);
      check("u2_xfer_at_done", 128'(n2_at_done), 128'd39);
      check("u2_count", 128'(q2.size()), 128'd39);
      check("u2_busy_drop", 128'(busy_drop), 128'd0);
      check("u2_gap_runs", 128'(gap_runs.size()), 128'd2);
      for (int k = 0; k < gap_runs.size(); k++)
         check($sformatf("u2_gap%0d", k), 128'(gap_runs[k]), 128'd4);
      bad = 0;
      for (int k = 0; k < q2.size(); k++) if (q2[k] !== msg[k % 13]) bad++;
      check("u2_bytes", 128'(bad), 128'd0);

      // Start-controlled runs.
      check("u3_idle_count", 128'(n3), 128'd0);
      check("u3_idle_busy", 128'(busy3), 128'd0);
      @(posedge clk); #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      @(negedge clk);
      check("u3_run_valid", 128'(if3.uhost_req_valid), 128'd1);
      check("u3_run_busy", 128'(busy3), 128'd1);
      repeat (3) @(posedge clk);
      #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      @(posedge clk); #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      guard = 0;
      while (!done3 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("u3_done1", 128'(done3), 128'd1);
      start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (if3.uhost_req_valid || busy3) extra++;
      end
      @(posedge clk); #1;
      $display("u3 run1: %0d transfers", n3);
      check("u3_count1", 128'(n3), 128'd13);
      check("u3_ignored_start", 128'(extra), 128'd0);
      start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      guard = 0;
      while (!done3 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("u3_done2", 128'(done3), 128'd1);
      @(posedge clk); #1;
      $display("u3 run2: %0d transfers total", n3);
      check("u3_count2", 128'(n3), 128'd26);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/umi_printer.md
Name: umi_printer

Overview:
- Parametrised UMI host-side message source. Streams a compile-time ASCII message to the emulation PUTC address as posted writes.
- Generalises the single-character hello block in four ways: multi-byte packing per request, repeat count, inter-pass gap, and start/busy/done control.
- Sits on a UMI host request port. The device request port is present but unused.

Parameters:
- CMD_WIDTH, 32: UMI command width.
- ADDR_WIDTH, 64: UMI address width.
- DATA_WIDTH, 128: UMI data width.
- MSG_LEN, 13: message length in characters; must be 1..255.
- MESSAGE, "Hello World!\n": 8*MSG_LEN-bit string. The first character is in the most significant byte.
- BYTES_PER_REQ, 1: characters packed per request; legal range 1..DATA_WIDTH/8.
- PUTC_ADDR, 'h1000000: destination address for every request.
- REPEAT, 1: number of message passes; 0 means repeat forever.
- GAP_CYCLES, 0: idle cycles with valid low between passes; legal range 0..65535.
- AUTOSTART, 1: when 1, a pass begins automatically after reset release.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- busy  out  1  high from the first request of a run until done.
- done  out  1  one-cycle pulse after the final handshake of a run.
- uhost_req_valid  out  1  request valid.
- uhost_req_cmd  out  CMD_WIDTH  command.
- uhost_req_dstaddr  out  ADDR_WIDTH  destination address; always PUTC_ADDR.
- uhost_req_srcaddr  out  ADDR_WIDTH  constant 0 (posted writes).
- uhost_req_data  out  DATA_WIDTH  packed characters.
- uhost_req_ready  in  1  downstream ready.
- udev_req_valid  in  1  unused.
- udev_req_cmd  in  CMD_WIDTH  unused.
- udev_req_dstaddr  in  ADDR_WIDTH  unused.
- udev_req_srcaddr  in  ADDR_WIDTH  unused.
- udev_req_data  in  DATA_WIDTH  unused.
- udev_req_ready  out  1  constant 0.

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high.
- Values while reset is high:
  - state = IDLE; valid = 0; busy = 0; done = 0.
  - cmd, dstaddr, data = 0; chunk and pass counters = 0.
- States: IDLE, SEND, GAP.
- IDLE to SEND:
  - Entered on the first clk edge with reset low if AUTOSTART = 1.
  - Otherwise entered on the edge where start = 1.
  - valid and busy rise on that same edge.
- Chunking:
  - NCHUNK = ceil(MSG_LEN / BYTES_PER_REQ).
  - Chunk k carries characters k*B .. min((k+1)*B, MSG_LEN) - 1.
  - Character i is placed in data byte (i - k*B), so the first character is in data[7:0].
  - Unused data bytes are 0.
- Command encoding:
  - cmd[7:0] = 8'h05 (posted write).
  - cmd[15:8] = nbytes - 1, where nbytes is the character count of the current chunk. Only the final chunk may be short.
  - All other cmd bits are 0.
- Handshake:
  - A transfer occurs on a clk edge where valid = 1 and ready = 1.
  - While valid = 1 and ready = 0, cmd, dstaddr and data hold stable and valid stays high.
  - After a transfer that is not the last chunk of the pass, the next chunk is presented on the same edge. There is no bubble, so back-to-back transfers are required at full throughput.
- End of pass, on the handshake of chunk NCHUNK-1:
  - If REPEAT != 0 and the completed pass count equals REPEAT: valid = 0, busy = 0, done = 1 for exactly one cycle, then IDLE.
  - Otherwise, if GAP_CYCLES = 0: the next pass begins immediately, with chunk 0 presented on the same edge.
  - Otherwise: go to GAP with valid = 0 for exactly GAP_CYCLES cycles, then SEND with chunk 0. busy stays 1 throughout.
- Pass counter: saturating; not advanced when REPEAT = 0.
- start: ignored in SEND and GAP. A start coincident with done is also ignored.
- Reset mid-operation: valid drops at that edge. No partial chunk is reissued. After release, AUTOSTART behaviour applies from chunk 0.
- Device port: udev_req_ready is permanently 0 and the udev_* inputs have no effect.

Test Plan:
- Default parameters, ready tied high:
  - 13 transfers on consecutive cycles; data[7:0] sequence 0x48, 0x65, ..., 0x0A.
  - cmd = 0x05, dstaddr = 0x1000000, srcaddr = 0.
  - done pulses once, one cycle after the 13th transfer; no further valid.
- BYTES_PER_REQ = 4:
  - 4 transfers; cmd values 0x305, 0x305, 0x305, 0x005.
  - First data[31:0] = 0x6C6C6548; last data = 0x0A with upper bytes 0.
- Back-pressure: hold ready low for 5 cycles mid-message -> valid stays 1 and payload is unchanged for all 5 cycles; the sequence resumes without loss or duplication.
- REPEAT = 3, GAP_CYCLES = 4:
  - 39 transfers in total, with exactly 4 valid-low cycles between passes.
  - busy high throughout; a single done pulse after transfer 39.
- AUTOSTART = 0:
  - No valid until a start pulse; start pulses during busy are ignored (still exactly 13 transfers).
  - A second start after done produces a second full run.
- Reset asserted after transfer 6:
  - valid = 0 on the reset edge.
  - After release, the message restarts with 0x48, and 13 complete transfers follow.
